wfifo_pack_sc: RTL and testbench

Single-clock, parametrised write-path FIFO that packs `IN_W`-bit write beats into `IN_W*RATIO`-bit words for the SDRAM controller's write datapath. It is the generalised successor of the fixed 8-to-16 write FIFO and is used where source and SDRAM share one clock. It adds the following over that FIFO:
- configurable width ratio and depth;
- lane order selection;
- fill level and almost-full/almost-empty thresholds;
- synchronous flush;
- sticky overflow/underflow error flags.

---
 rtl/wfifo_pack_if.sv | 36 +++
 rtl/wfifo_pack_sc.sv | 120 ++++++++++++
 tb/tb_wfifo_pack_sc.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wfifo_pack_if.sv
// Handshake bundle between a write-beat source / word reader and wfifo_pack_sc.
interface wfifo_pack_if #(
   parameter int IN_W  = 8,
   parameter int RATIO = 2,
   parameter int DEPTH = 256
);
   localparam int OUT_W  = IN_W * RATIO;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int LANE_W = $clog2(RATIO);

   logic              fifo_flush;
   logic              fifo_wr_en;
   logic [IN_W-1:0]   fifo_wr_data;
   logic              fifo_full;
   logic              fifo_rd_en;
   logic [OUT_W-1:0]  fifo_rd_data;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_afull;
   logic              fifo_aempty;
   logic [LANE_W-1:0] fifo_lane;
   logic              fifo_ovf;
   logic              fifo_udf;

   modport master (
      output fifo_flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
      input  fifo_full, fifo_rd_data, fifo_empty, fifo_cnt, fifo_afull,
             fifo_aempty, fifo_lane, fifo_ovf, fifo_udf
   );

   modport slave (
      input  fifo_flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
      output fifo_full, fifo_rd_data, fifo_empty, fifo_cnt, fifo_afull,
             fifo_aempty, fifo_lane, fifo_ovf, fifo_udf
   );
endinterface

// File: rtl/wfifo_pack_sc.sv
// Single-clock write FIFO that packs RATIO beats of IN_W bits into one stored word,
// with fill level, threshold flags, synchronous flush and sticky error flags.
module wfifo_pack_sc #(
   parameter int IN_W      = 8,
   parameter int RATIO     = 2,
   parameter int DEPTH     = 256,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        fifo_clk,
   input  logic        rst_n,
   wfifo_pack_if.slave fifo
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int LANE_W = $clog2(RATIO);

   typedef logic [RATIO-1:0][IN_W-1:0] word_t;

   // NOTE: the storage array has no reset; only pointers and count are cleared,
   // which is what makes its contents unobservable and lets it map onto RAM.
   word_t mem [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   word_t             pack_q, pack_d;
   word_t             rd_data_q, rd_data_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic              full, empty;
   logic              wr_acc, rd_acc, commit;
   logic [LANE_W-1:0] slot;
   word_t             word_asm;

   // NOTE: every signal assigned here gets a value on every path (defaults
   // first), so no latches are inferred.
   always_comb begin
      full     = (cnt_q == CNT_W'(DEPTH));
      empty    = (cnt_q == '0);
      wr_acc   = fifo.fifo_wr_en && !full && !fifo.fifo_flush;
      rd_acc   = fifo.fifo_rd_en && !empty && !fifo.fifo_flush;
      commit   = wr_acc && (lane_q == LANE_W'(RATIO - 1));
      slot     = MSB_FIRST ? (LANE_W'(RATIO - 1) - lane_q) : lane_q;

      // The word written on commit already contains the completing beat.
      word_asm       = pack_q;
      word_asm[slot] = fifo.fifo_wr_data;

      pack_d    = wr_acc ? word_asm : pack_q;
      lane_d    = lane_q;
      if (wr_acc) lane_d = commit ? '0 : lane_q + LANE_W'(1);

      wr_ptr_d  = wr_ptr_q + PTR_W'(commit);
      rd_ptr_d  = rd_ptr_q + PTR_W'(rd_acc);
      rd_data_d = rd_acc ? mem[rd_ptr_q] : rd_data_q;

      cnt_d = cnt_q;
      case ({commit, rd_acc})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      ovf_d = ovf_q | (fifo.fifo_wr_en & full);
      udf_d = udf_q | (fifo.fifo_rd_en & empty);

      // Flush wins over everything; stale packer bits are simply overwritten
      // lane by lane once fifo_lane restarts at 0.
      if (fifo.fifo_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         lane_d   = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge fifo_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         lane_q    <= '0;
         pack_q    <= '0;
         rd_data_q <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         lane_q    <= lane_d;
         pack_q    <= pack_d;
         rd_data_q <= rd_data_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   always_ff @(posedge fifo_clk) begin
      if (commit) mem[wr_ptr_q] <= word_asm;
   end

   assign fifo.fifo_full    = full;
   assign fifo.fifo_empty   = empty;
   assign fifo.fifo_afull   = (cnt_q >= CNT_W'(AF_THRESH));
   assign fifo.fifo_aempty  = (cnt_q <= CNT_W'(AE_THRESH));
   assign fifo.fifo_cnt     = cnt_q;
   assign fifo.fifo_lane    = lane_q;
   assign fifo.fifo_rd_data = rd_data_q;
   assign fifo.fifo_ovf     = ovf_q;
   assign fifo.fifo_udf     = udf_q;
endmodule

// File: tb/tb_wfifo_pack_sc.sv
// Bench for wfifo_pack_sc: LSB-first and MSB-first instances share one stimulus
// stream and are compared against a queue-based model of the packing FIFO.
module tb_wfifo_pack_sc;
   localparam int IN_W      = 8;
   localparam int RATIO     = 2;
   localparam int DEPTH     = 256;
   localparam int AF_THRESH = DEPTH - 4;
   localparam int AE_THRESH = 4;
   localparam int OUT_W     = IN_W * RATIO;
   localparam int CNT_W     = $clog2(DEPTH + 1);
   localparam int LANE_W    = $clog2(RATIO);

   logic            fifo_clk = 1'b0;
   logic            rst_n;
   logic            flush, wr_en, rd_en;
   logic [IN_W-1:0] wr_data;
   int              n_chk = 0;
   int              n_err = 0;

   always #5 fifo_clk = ~fifo_clk;

   wfifo_pack_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) b0 ();
   wfifo_pack_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) b1 ();

   assign b0.fifo_flush   = flush;
   assign b0.fifo_wr_en   = wr_en;
   assign b0.fifo_wr_data = wr_data;
   assign b0.fifo_rd_en   = rd_en;
   assign b1.fifo_flush   = flush;
   assign b1.fifo_wr_en   = wr_en;
   assign b1.fifo_wr_data = wr_data;
   assign b1.fifo_rd_en   = rd_en;

   wfifo_pack_sc #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH),
                   .AE_THRESH(AE_THRESH), .MSB_FIRST(1'b0))
      u_lsb (.fifo_clk(fifo_clk), .rst_n(rst_n), .fifo(b0.slave));

   wfifo_pack_sc #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH),
                   .AE_THRESH(AE_THRESH), .MSB_FIRST(1'b1))
      u_msb (.fifo_clk(fifo_clk), .rst_n(rst_n), .fifo(b1.slave));

   // Flag vector per instance: {full, empty, afull, aempty, ovf, udf}
   logic [5:0]        flg  [2];
   logic [CNT_W-1:0]  cnt  [2];
   logic [LANE_W-1:0] lane [2];
   logic [OUT_W-1:0]  rdat [2];

   assign flg[0]  = {b0.fifo_full, b0.fifo_empty, b0.fifo_afull, b0.fifo_aempty, b0.fifo_ovf, b0.fifo_udf};
   assign flg[1]  = {b1.fifo_full, b1.fifo_empty, b1.fifo_afull, b1.fifo_aempty, b1.fifo_ovf, b1.fifo_udf};
   assign cnt[0]  = b0.fifo_cnt;
   assign cnt[1]  = b1.fifo_cnt;
   assign lane[0] = b0.fifo_lane;
   assign lane[1] = b1.fifo_lane;
   assign rdat[0] = b0.fifo_rd_data;
   assign rdat[1] = b1.fifo_rd_data;

   // Reference model: words kept in arrival order with the first beat lowest.
   logic [IN_W-1:0]  m_part  [$];
   logic [OUT_W-1:0] m_words [$];
   logic [OUT_W-1:0] m_rd;
   logic             m_ovf, m_udf;

   function automatic logic [OUT_W-1:0] reorder(input logic [OUT_W-1:0] w);
      logic [OUT_W-1:0] r;
      r = '0;
      for (int i = 0; i < RATIO; i++) r[(RATIO-1-i)*IN_W +: IN_W] = w[i*IN_W +: IN_W];
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] exp_rd(input int d);
      return (d == 0) ? m_rd : reorder(m_rd);
   endfunction

   function automatic logic [5:0] exp_flags(input int c, input logic o, input logic u);
      return {c == DEPTH, c == 0, c >= AF_THRESH, c <= AE_THRESH, o, u};
   endfunction

   task automatic model_reset();
      m_part.delete();
      m_words.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic model_step();
      logic [OUT_W-1:0] w;
      bit full_pre, empty_pre;
      if (flush) begin
         m_part.delete();
         m_words.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         return;
      end
      full_pre  = (m_words.size() == DEPTH);
      empty_pre = (m_words.size() == 0);
      if (rd_en) begin
         if (empty_pre) m_udf = 1'b1;
         else m_rd = m_words.pop_front();
      end
      if (wr_en) begin
         if (full_pre) m_ovf = 1'b1;
         else begin
            m_part.push_back(wr_data);
            if (m_part.size() == RATIO) begin
               w = '0;
               for (int i = 0; i < RATIO; i++) w[i*IN_W +: IN_W] = m_part[i];
               m_words.push_back(w);
               m_part.delete();
            end
         end
      end
   endtask

   task automatic do_cycle(input logic f, input logic w, input logic [IN_W-1:0] dt, input logic r);
      flush   = f;
      wr_en   = w;
      wr_data = dt;
      rd_en   = r;
      @(posedge fifo_clk);
      model_step();
      #1;
      flush = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      model_reset();
      #2;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (flg[d] !== 6'b010100) begin
            n_err++; $display("FAIL reset_flags[%0d]: got %b expected %b", d, flg[d], 6'b010100);
         end
         n_chk++;
         if (cnt[d] !== '0 || lane[d] !== '0 || rdat[d] !== '0) begin
            n_err++; $display("FAIL reset_state[%0d]: cnt=%0d lane=%0d rd=%h expected all 0", d, cnt[d], lane[d], rdat[d]);
         end
      end
      @(negedge fifo_clk);
      rst_n = 1'b1;
   endtask

   task automatic test_pack_order();
      do_cycle(1'b0, 1'b1, 8'h11, 1'b0);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (flg[d][4] !== 1'b1 || lane[d] !== LANE_W'(1)) begin
            n_err++; $display("FAIL pack_first_beat[%0d]: empty=%b lane=%0d expected empty=1 lane=1", d, flg[d][4], lane[d]);
         end
      end
      do_cycle(1'b0, 1'b1, 8'h22, 1'b0);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (flg[d][4] !== 1'b0 || cnt[d] !== CNT_W'(1) || lane[d] !== '0) begin
            n_err++; $display("FAIL pack_commit[%0d]: empty=%b cnt=%0d lane=%0d expected 0/1/0", d, flg[d][4], cnt[d], lane[d]);
         end
      end
      do_cycle(1'b0, 1'b0, '0, 1'b1);
      n_chk++;
      if (rdat[0] !== 16'h2211) begin
         n_err++; $display("FAIL pack_lsb_first: got %h expected 2211", rdat[0]);
      end
      n_chk++;
      if (rdat[1] !== 16'h1122) begin
         n_err++; $display("FAIL pack_msb_first: got %h expected 1122", rdat[1]);
      end
   endtask

   task automatic test_fill_overflow();
      int exp_c;
      for (int i = 0; i < 2*DEPTH; i++) begin
         do_cycle(1'b0, 1'b1, IN_W'($urandom), 1'b0);
         exp_c = (i + 1) / 2;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (cnt[d] !== CNT_W'(exp_c) || flg[d][3] !== (exp_c >= AF_THRESH) || flg[d][5] !== (exp_c == DEPTH)) begin
               n_err++;
               $display("FAIL fill_level[%0d] beat %0d: cnt=%0d afull=%b full=%b expected cnt=%0d afull=%b full=%b",
                        d, i, cnt[d], flg[d][3], flg[d][5], exp_c, exp_c >= AF_THRESH, exp_c == DEPTH);
            end
         end
      end
      do_cycle(1'b0, 1'b1, 8'hEE, 1'b0);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (flg[d][1] !== 1'b1 || lane[d] !== '0 || cnt[d] !== CNT_W'(DEPTH) || flg[d][5] !== 1'b1) begin
            n_err++;
            $display("FAIL overflow[%0d]: ovf=%b lane=%0d cnt=%0d full=%b expected ovf=1 lane=0 cnt=%0d full=1",
                     d, flg[d][1], lane[d], cnt[d], flg[d][5], DEPTH);
         end
      end
   endtask

   task automatic test_drain_underflow();
      int exp_c;
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle(1'b0, 1'b0, '0, 1'b1);
         exp_c = DEPTH - 1 - i;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (rdat[d] !== exp_rd(d) || cnt[d] !== CNT_W'(exp_c) ||
                flg[d][4] !== (exp_c == 0) || flg[d][2] !== (exp_c <= AE_THRESH)) begin
               n_err++;
               $display("FAIL drain[%0d] read %0d: rd=%h cnt=%0d empty=%b aempty=%b expected rd=%h cnt=%0d empty=%b aempty=%b",
                        d, i, rdat[d], cnt[d], flg[d][4], flg[d][2], exp_rd(d), exp_c, exp_c == 0, exp_c <= AE_THRESH);
            end
         end
      end
      do_cycle(1'b0, 1'b0, '0, 1'b1);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (flg[d][0] !== 1'b1 || rdat[d] !== exp_rd(d) || flg[d][4] !== 1'b1) begin
            n_err++;
            $display("FAIL underflow[%0d]: udf=%b rd=%h empty=%b expected udf=1 rd=%h empty=1",
                     d, flg[d][0], rdat[d], flg[d][4], exp_rd(d));
         end
      end
   endtask

   task automatic test_stream_wrap();
      for (int i = 0; i < 2*RATIO; i++) do_cycle(1'b0, 1'b1, IN_W'($urandom), 1'b0);
      for (int k = 0; k < 3*DEPTH; k++) begin
         do_cycle(1'b0, 1'b1, IN_W'($urandom), 1'b0);
         do_cycle(1'b0, 1'b1, IN_W'($urandom), 1'b1);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (cnt[d] !== CNT_W'(2) || lane[d] !== '0 || rdat[d] !== exp_rd(d)) begin
               n_err++;
               $display("FAIL stream[%0d] word %0d: cnt=%0d lane=%0d rd=%h expected cnt=2 lane=0 rd=%h",
                        d, k, cnt[d], lane[d], rdat[d], exp_rd(d));
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [OUT_W-1:0] hold;
      do_cycle(1'b0, 1'b0, '0, 1'b1);
      do_cycle(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 5*RATIO + 1; i++) do_cycle(1'b0, 1'b1, IN_W'($urandom), 1'b0);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (cnt[d] !== CNT_W'(5) || lane[d] !== LANE_W'(1)) begin
            n_err++; $display("FAIL flush_setup[%0d]: cnt=%0d lane=%0d expected 5/1", d, cnt[d], lane[d]);
         end
      end
      hold = m_rd;
      do_cycle(1'b1, 1'b1, 8'h5A, 1'b1);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (cnt[d] !== '0 || lane[d] !== '0 || flg[d] !== 6'b010100 ||
             rdat[d] !== ((d == 0) ? hold : reorder(hold))) begin
            n_err++;
            $display("FAIL flush[%0d]: cnt=%0d lane=%0d flags=%b rd=%h expected 0/0/010100/%h",
                     d, cnt[d], lane[d], flg[d], rdat[d], (d == 0) ? hold : reorder(hold));
         end
      end
      do_cycle(1'b0, 1'b1, 8'hA1, 1'b0);
      do_cycle(1'b0, 1'b1, 8'hB2, 1'b0);
      do_cycle(1'b0, 1'b0, '0, 1'b1);
      n_chk++;
      if (rdat[0] !== 16'hB2A1 || rdat[1] !== 16'hA1B2) begin
         n_err++; $display("FAIL flush_repack: got %h/%h expected b2a1/a1b2", rdat[0], rdat[1]);
      end
   endtask

   task automatic test_async_reset();
      do_cycle(1'b0, 1'b1, 8'h33, 1'b0);
      do_cycle(1'b0, 1'b1, 8'h44, 1'b0);
      do_cycle(1'b0, 1'b1, 8'h55, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (flg[d] !== 6'b010100 || cnt[d] !== '0 || lane[d] !== '0 || rdat[d] !== '0) begin
            n_err++;
            $display("FAIL async_reset[%0d]: flags=%b cnt=%0d lane=%0d rd=%h expected 010100/0/0/0",
                     d, flg[d], cnt[d], lane[d], rdat[d]);
         end
      end
      model_reset();
      @(negedge fifo_clk);
      rst_n = 1'b1;
      do_cycle(1'b0, 1'b1, 8'h66, 1'b0);
      do_cycle(1'b0, 1'b1, 8'h77, 1'b0);
      do_cycle(1'b0, 1'b0, '0, 1'b1);
      n_chk++;
      if (rdat[0] !== 16'h7766 || rdat[1] !== 16'h6677 || cnt[0] !== '0) begin
         n_err++; $display("FAIL post_reset_word: got %h/%h cnt=%0d expected 7766/6677 cnt=0", rdat[0], rdat[1], cnt[0]);
      end
   endtask

   task automatic test_random();
      int wr_pct, rd_pct, c;
      for (int ph = 0; ph < 4; ph++) begin
         wr_pct = (ph % 2 == 0) ? 95 : 30;
         rd_pct = (ph % 2 == 0) ? 25 : 90;
         for (int i = 0; i < 800; i++) begin
            do_cycle($urandom_range(0, 127) == 0, $urandom_range(0, 99) < wr_pct,
                     IN_W'($urandom), $urandom_range(0, 99) < rd_pct);
            c = m_words.size();
            for (int d = 0; d < 2; d++) begin
               n_chk++;
               if (cnt[d] !== CNT_W'(c) || lane[d] !== LANE_W'(m_part.size()) ||
                   flg[d] !== exp_flags(c, m_ovf, m_udf) || rdat[d] !== exp_rd(d)) begin
                  n_err++;
                  $display("FAIL random[%0d] ph%0d cyc%0d: cnt=%0d lane=%0d flags=%b rd=%h expected cnt=%0d lane=%0d flags=%b rd=%h",
                           d, ph, i, cnt[d], lane[d], flg[d], rdat[d], c, m_part.size(),
                           exp_flags(c, m_ovf, m_udf), exp_rd(d));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_pack_order();
      test_fill_overflow();
      test_drain_underflow();
      test_stream_wrap();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
